// File: rtl/alu_cmd_if.sv
// Command / ALU / response signal bundle for alu_cmd_driver.
interface alu_cmd_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned CNT_W  = 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_strobe;
    logic [DATA_W-1:0] alu_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_y;
    logic [TAG_W-1:0]  rsp_tag;
    logic [CNT_W-1:0]  drop_cnt;

    // Environment side: issues commands, models the ALU, consumes responses.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_strobe,
               rsp_valid, rsp_y, rsp_tag, drop_cnt
    );

    // Driver side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_strobe,
               rsp_valid, rsp_y, rsp_tag, drop_cnt
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Drives one command at a time into a fixed-latency ALU and returns the
// captured result with a sequence tag; unclaimed results are dropped after
// a timeout and counted.
module alu_cmd_driver #(
    parameter int unsigned RESULT_LAT = 2,
    parameter int unsigned TIMEOUT    = 12
) (
    input logic      clk,
    input logic      rst_n,
    alu_cmd_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned TO_W   = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_nxt;
    logic              w_hs;
    logic              w_capture;
    logic              w_drop;

    logic              r_cmd_ready;
    logic              r_alu_strobe;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_rsp_y;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [TAG_W-1:0]  r_seq;
    logic [CNT_W-1:0]  r_drop_cnt;

    // State and latency/timeout counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_to_cnt   <= w_to_nxt;
        end
    end

    // Next-state, counter updates and datapath enables.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_to_nxt    = r_to_cnt;
        w_hs        = 1'b0;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_wait_nxt  = WAIT_W'(RESULT_LAT - 1);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_to_nxt    = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_wait_nxt = r_wait_cnt - WAIT_W'(1);
                end
            end
            S_RESP: begin
                // Acceptance wins over an expiry landing in the same cycle.
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, operand latch, result capture and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready  <= 1'b1;
            r_alu_strobe <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_y      <= '0;
            r_rsp_tag    <= '0;
            r_seq        <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_cmd_ready  <= (w_state_nxt == S_IDLE);
            r_alu_strobe <= (w_state_nxt == S_DRIVE);
            r_rsp_valid  <= (w_state_nxt == S_RESP);
            if (w_hs) begin
                r_alu_a   <= bus.cmd_a;
                r_alu_b   <= bus.cmd_b;
                r_alu_op  <= bus.cmd_op;
                r_rsp_tag <= r_seq;
                r_seq     <= r_seq + TAG_W'(1);
            end
            if (w_capture) begin
                r_rsp_y <= bus.alu_y;
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.alu_strobe = r_alu_strobe;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_y      = r_rsp_y;
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: vector table plus hand sequences
// for timeout, saturation, reset abort and tag wrap.
module tb_alu_cmd_driver;
    localparam int unsigned RESULT_LAT = 2;
    localparam int unsigned TIMEOUT    = 12;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] tag;
    } rsp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        int         delay;
    } vec_t;

    logic clk;
    logic rst_n;
    alu_cmd_if bus ();

    alu_cmd_driver #(
        .RESULT_LAT (RESULT_LAT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_tag = '0;
    logic [7:0] exp_drop = '0;
    rsp_t       sb[$];
    vec_t       vecs[8];
    int unsigned lat_k = 99;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a ^ b;
            4'd4:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // ALU model: correct result only in the capture cycle, inverted garbage otherwise.
    always @(negedge clk) begin
        if (bus.alu_strobe) lat_k = 0;
        else if (lat_k < 99) lat_k = lat_k + 1;
        bus.alu_y = (lat_k == RESULT_LAT) ? alu_f(bus.alu_op, bus.alu_a, bus.alu_b)
                                          : ~alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        exp_tag  = '0;
        exp_drop = '0;
        sb.delete();
    endtask

    // One full transaction; entered and left on a negedge.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] y, input int delay, input bit drop);
        bit   hs;
        bit   bad;
        int   n;
        int   extra;
        rsp_t exp;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        hs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin
                hs = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hs) begin
            bus.cmd_valid = 1'b0;
            check("handshake", 64'(0), 64'(1));
            return;
        end
        sb.push_back('{y: y, tag: exp_tag});
        exp_tag = exp_tag + 4'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("strobe", 64'(bus.alu_strobe), 64'(1));
        check("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
        check("alu_operands", 64'({bus.alu_op, bus.alu_a, bus.alu_b}), 64'({op, a, b}));
        n = 0;
        extra = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.alu_strobe) extra++;
        end
        check("latency", 64'(n), 64'(RESULT_LAT + 1));
        check("strobe_single", 64'(extra), 64'(0));
        if (!bus.rsp_valid) return;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'(0), 64'(1));
            return;
        end
        exp = sb.pop_front();
        check("rsp_y", 64'(bus.rsp_y), 64'(exp.y));
        check("rsp_tag", 64'(bus.rsp_tag), 64'(exp.tag));
        if (drop) begin
            n = 1;
            while (bus.rsp_valid && n < 40) begin
                @(negedge clk);
                if (bus.rsp_valid) n++;
            end
            exp_drop = (exp_drop == 8'hFF) ? 8'hFF : exp_drop + 8'd1;
            check("timeout_cycles", 64'(n), 64'(TIMEOUT));
            check("drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
            check("idle_after_drop", 64'(bus.cmd_ready), 64'(1));
        end else begin
            bad = 1'b0;
            for (int j = 0; j < delay; j++) begin
                @(negedge clk);
                if (!bus.rsp_valid || bus.rsp_y !== exp.y || bus.rsp_tag !== exp.tag ||
                    {bus.alu_op, bus.alu_a, bus.alu_b} !== {op, a, b})
                    bad = 1'b1;
            end
            check("rsp_stable", 64'(bad), 64'(0));
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            check("accept_idle", 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
            check("drop_cnt_kept", 64'(bus.drop_cnt), 64'(exp_drop));
        end
    endtask

    initial begin
        int  nrsp;
        int  nstb;
        int  first_c;
        int  last_c;
        bit  bad;

        vecs[0] = '{op: 4'h1, a: 8'h12, b: 8'h34, y: 8'h46, delay: 0};
        vecs[1] = '{op: 4'h1, a: 8'hFF, b: 8'h01, y: 8'h00, delay: 5};
        vecs[2] = '{op: 4'h2, a: 8'h10, b: 8'h20, y: 8'hF0, delay: 1};
        vecs[3] = '{op: 4'h3, a: 8'hF0, b: 8'h3C, y: 8'hCC, delay: 11};
        vecs[4] = '{op: 4'h4, a: 8'h0F, b: 8'h30, y: 8'h3F, delay: 0};
        vecs[5] = '{op: 4'h0, a: 8'hF0, b: 8'h3C, y: 8'h30, delay: 2};
        vecs[6] = '{op: 4'h2, a: 8'h34, b: 8'h12, y: 8'h22, delay: 3};
        vecs[7] = '{op: 4'h1, a: 8'h80, b: 8'h80, y: 8'h00, delay: 0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_ctrl", 64'({bus.cmd_ready, bus.alu_strobe, bus.rsp_valid}), 64'(3'b100));
        check("reset_data", 64'({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_y, bus.rsp_tag, bus.drop_cnt}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: basic, backpressure, expiry race (delay 11), misc ops.
        for (int i = 0; i < 8; i++)
            do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].delay, 1'b0);

        // Timeout drop, then saturation of the drop counter.
        do_cmd(4'h1, 8'h40, 8'h02, 8'h42, 0, 1'b1);
        for (int i = 0; i < 256; i++)
            do_cmd(4'h2, 8'(i), 8'h01, 8'(i - 1), 0, 1'b1);
        check("drop_sat", 64'(bus.drop_cnt), 64'(255));

        // Asynchronous reset while waiting for the ALU result.
        bus.cmd_op = 4'h1; bus.cmd_a = 8'h21; bus.cmd_b = 8'h01; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl", 64'({bus.cmd_ready, bus.alu_strobe, bus.rsp_valid}), 64'(3'b100));
        check("abort_data", 64'({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_y, bus.rsp_tag, bus.drop_cnt}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_tag = '0; exp_drop = '0; sb.delete();
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) bad = 1'b1;
        end
        check("no_rsp_after_abort", 64'(bad), 64'(0));
        do_cmd(4'h1, 8'h21, 8'h01, 8'h22, 0, 1'b0);

        // Tag wrap with cmd_valid held high and the consumer always ready.
        apply_reset();
        bus.cmd_op = 4'h3; bus.cmd_a = 8'h55; bus.cmd_b = 8'h0F;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        nrsp = 0; nstb = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 300 && nrsp < 17; c++) begin
            @(negedge clk);
            if (bus.alu_strobe) nstb++;
            if (bus.rsp_valid) begin
                check("wrap_tag", 64'(bus.rsp_tag), 64'(nrsp % 16));
                check("wrap_y", 64'(bus.rsp_y), 64'(8'h5A));
                if (nrsp == 0) first_c = c;
                last_c = c;
                nrsp++;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("wrap_count", 64'(nrsp), 64'(17));
        check("wrap_strobes", 64'(nstb), 64'(17));
        check("wrap_spacing", 64'(last_c - first_c), 64'(80));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
